// File: rtl/data_mem_responder.sv
// Data memory responder for the MEM stage: accepts one load/store at a time,
// answers LATENCY cycles later with rvalid_o, rdata_o and err_o.
// Ports: clk, rst (async, active-low); request req_i/we_i/funct3_i/addr_i/wdata_i;
// handshake ready_o/stall_o; response rvalid_o/rdata_o/err_o.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        stall_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int WORDS = 2 ** (ADDR_WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t state, state_n;
  logic [3:0] cnt, cnt_n;

  logic                  we_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q;
  logic                  err_q;

  logic [31:0] mem [WORDS];

  // High address bits are deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^addr_i[31:ADDR_WIDTH];

  // In IDLE the live inputs describe the transaction being accepted;
  // afterwards only the latched copy is used.
  logic                  c_we;
  logic [2:0]            c_f3;
  logic [ADDR_WIDTH-1:0] c_addr;

  assign c_we   = (state == IDLE) ? we_i : we_q;
  assign c_f3   = (state == IDLE) ? funct3_i : f3_q;
  assign c_addr = (state == IDLE) ? addr_i[ADDR_WIDTH-1:0] : addr_q;

  logic is_b, is_h, is_w, is_bu, is_hu;
  logic legal, misal, c_err;

  assign is_b  = (c_f3 == 3'b000);
  assign is_h  = (c_f3 == 3'b001);
  assign is_w  = (c_f3 == 3'b010);
  assign is_bu = (c_f3 == 3'b100);
  assign is_hu = (c_f3 == 3'b101);

  assign legal = is_b | is_h | is_w | (~c_we & (is_bu | is_hu));
  assign misal = ((is_h | is_hu) & c_addr[0]) |
                 (is_w & (c_addr[1:0] != 2'b00));
  assign c_err = ~legal | misal;

  logic [31:0] rword, shifted, ld_val;

  assign rword   = mem[c_addr[ADDR_WIDTH-1:2]];
  assign shifted = rword >> {c_addr[1:0], 3'b000};

  always_comb begin
    ld_val = '0;
    unique case (1'b1)
      is_b:    ld_val = {{24{shifted[7]}}, shifted[7:0]};
      is_h:    ld_val = {{16{shifted[15]}}, shifted[15:0]};
      is_w:    ld_val = rword;
      is_bu:   ld_val = {24'b0, shifted[7:0]};
      is_hu:   ld_val = {16'b0, shifted[15:0]};
      default: ld_val = '0;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // FSM: next state
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (req_i) begin
          if (LATENCY == 1) begin
            state_n = RESP;
          end else begin
            state_n = BUSY;
            cnt_n   = 4'(LATENCY - 2);
          end
        end
      end
      BUSY: begin
        if (cnt == 4'd0) state_n = RESP;
        else             cnt_n   = cnt - 4'd1;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ready_o  = (state == IDLE);
    stall_o  = req_i && (state != RESP);
    rvalid_o = (state == RESP);
    rdata_o  = rdata_q;
    err_o    = err_q;
  end

  // Transaction latch, and response registers loaded on entry to RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == IDLE && req_i) begin
        we_q    <= we_i;
        f3_q    <= funct3_i;
        addr_q  <= addr_i[ADDR_WIDTH-1:0];
        wdata_q <= wdata_i;
      end
      if (state_n == RESP) begin
        err_q   <= c_err;
        rdata_q <= (!c_we && !c_err) ? ld_val : '0;
      end else begin
        err_q   <= 1'b0;
        rdata_q <= '0;
      end
    end
  end

  // Store lanes; only meaningful in RESP where the latched copy is live.
  logic [3:0]  be;
  logic [31:0] wd;

  always_comb begin
    be = 4'b0000;
    wd = wdata_q;
    unique case (1'b1)
      is_b: begin
        be = 4'b0001 << addr_q[1:0];
        wd = {4{wdata_q[7:0]}};
      end
      is_h: begin
        be = 4'b0011 << addr_q[1:0];
        wd = {2{wdata_q[15:0]}};
      end
      is_w: begin
        be = 4'b1111;
        wd = wdata_q;
      end
      default: be = 4'b0000;
    endcase
  end

  // Array is not reset; a reset forces IDLE so a pending store never lands.
  always_ff @(posedge clk) begin
    if (state == RESP && we_q && !err_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr_q[ADDR_WIDTH-1:2]][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three builds (LATENCY 2, 1, 4) driven in
// parallel, checked each cycle against a transaction-level model.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic        we;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  ready, stall, rvalid, err;
  logic [31:0] rdata [3];

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_WIDTH(17), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .req_i(req[0]), .we_i(we), .funct3_i(f3),
    .addr_i(addr), .wdata_i(wdata), .ready_o(ready[0]), .stall_o(stall[0]),
    .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]));

  data_mem_responder #(.ADDR_WIDTH(17), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .req_i(req[1]), .we_i(we), .funct3_i(f3),
    .addr_i(addr), .wdata_i(wdata), .ready_o(ready[1]), .stall_o(stall[1]),
    .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]));

  data_mem_responder #(.ADDR_WIDTH(17), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .req_i(req[2]), .we_i(we), .funct3_i(f3),
    .addr_i(addr), .wdata_i(wdata), .ready_o(ready[2]), .stall_o(stall[2]),
    .rvalid_o(rvalid[2]), .rdata_o(rdata[2]), .err_o(err[2]));

  int errors = 0;
  int checks = 0;
  int cnt = 0;

  // model: per instance, cycles since acceptance (0 = idle) and the txn
  int          age    [3];
  bit          t_we   [3];
  bit [2:0]    t_f3   [3];
  bit [31:0]   t_addr [3];
  bit [31:0]   t_wd   [3];
  logic [31:0] mm [int];

  // observed responses
  int          rv_n    [3];
  int          rv_at   [3];
  logic [31:0] last_rd [3];
  logic        last_err[3];

  function automatic int lat(int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
  endfunction

  function automatic int mkey(int k, bit [31:0] a);
    return k * 1000000 + int'(a[16:2]);
  endfunction

  function automatic bit m_err(bit w, bit [2:0] f, bit [1:0] a);
    bit ok;
    if (w) ok = (f <= 3'd2);
    else   ok = (f <= 3'd2) || (f == 3'd4) || (f == 3'd5);
    if (!ok) return 1'b1;
    if ((f == 3'd1 || f == 3'd5) && a[0]) return 1'b1;
    if (f == 3'd2 && a != 2'd0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(logic [31:0] wv, bit [2:0] f,
                                         bit [1:0] a);
    logic [31:0] v;
    v = wv >> (8 * int'(a));
    case (f)
      3'd0:    return {{24{v[7]}}, v[7:0]};
      3'd1:    return {{16{v[15]}}, v[15:0]};
      3'd2:    return wv;
      3'd4:    return {24'b0, v[7:0]};
      3'd5:    return {16'b0, v[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_store(logic [31:0] old, bit [2:0] f,
                                          bit [1:0] a, bit [31:0] d);
    logic [31:0] r;
    int n;
    r = old;
    n = (f == 3'd0) ? 1 : ((f == 3'd1) ? 2 : 4);
    for (int i = 0; i < n; i++) r[8*(int'(a)+i) +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lat%0d got=%h want=%h t=%0t", nm, lat(k), act, exp,
               $time);
    end
  endtask

  // compare on the falling edge, advance the model on the rising edge
  initial begin
    for (int k = 0; k < 3; k++) age[k] = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        bit rv, e;
        int key;
        if (!rst) age[k] = 0;
        rv  = (age[k] != 0) && (age[k] == lat(k));
        e   = rv && m_err(t_we[k], t_f3[k], t_addr[k][1:0]);
        key = mkey(k, t_addr[k]);
        chk("ready", k, 32'(ready[k]), 32'(age[k] == 0));
        chk("stall", k, 32'(stall[k]), 32'(req[k] && !rv));
        chk("rvalid", k, 32'(rvalid[k]), 32'(rv));
        chk("err", k, 32'(err[k]), 32'(e));
        if (rv && !t_we[k] && !e) begin
          if (mm.exists(key))
            chk("rdata", k, rdata[k],
                m_load(mm[key], t_f3[k], t_addr[k][1:0]));
        end else begin
          chk("rdata", k, rdata[k], 32'h0);
        end
        if (rvalid[k]) begin
          rv_n[k]++;
          rv_at[k]    = cnt;
          last_rd[k]  = rdata[k];
          last_err[k] = err[k];
        end
      end
      @(posedge clk);
      cnt++;
      if (rst) begin
        for (int k = 0; k < 3; k++) begin
          if (age[k] == 0) begin
            if (req[k]) begin
              t_we[k]   = we;
              t_f3[k]   = f3;
              t_addr[k] = addr;
              t_wd[k]   = wdata;
              age[k]    = 1;
            end
          end else if (age[k] == lat(k)) begin
            if (t_we[k] && !m_err(t_we[k], t_f3[k], t_addr[k][1:0])) begin
              int key;
              key = mkey(k, t_addr[k]);
              mm[key] = m_store(mm.exists(key) ? mm[key] : 32'h0,
                                t_f3[k], t_addr[k][1:0], t_wd[k]);
            end
            age[k] = 0;
          end else begin
            age[k]++;
          end
        end
      end
    end
  end

  // One transaction on the instances in m. hold keeps req high through
  // RESP; rst_mid pulses reset right after acceptance.
  task automatic op(input bit [2:0] m, input bit hold, input bit rst_mid,
                    input bit w, input bit [2:0] f, input bit [31:0] a,
                    input bit [31:0] d);
    int acc;
    acc = 0;
    @(posedge clk); #1;
    we = w; f3 = f; addr = a; wdata = d; req = m;
    for (int k = 0; k < 3; k++) rv_n[k] = 0;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        acc = cnt;
        we = ~w; f3 = 3'b111; addr = a ^ 32'h4; wdata = ~d;
        if (rst_mid) rst = 1'b0;
      end
      if (c == 3 && rst_mid) rst = 1'b1;
      for (int k = 0; k < 3; k++)
        if (c >= (hold ? lat(k) + 1 : 1)) req[k] = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      if (m[k]) begin
        chk("rv_count", k, rv_n[k], rst_mid ? 32'd0 : 32'd1);
        if (!rst_mid) chk("rv_time", k, rv_at[k], acc + lat(k) - 1);
      end
    end
  endtask

  bit [2:0]    ext_f3 [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd0};
  bit [31:0]   ext_a  [5] = '{32'h20, 32'h20, 32'h22, 32'h22, 32'h21};
  logic [31:0] ext_x  [5] = '{32'hFFFFFF82, 32'h00000082, 32'hFFFF80F1,
                              32'h000080F1, 32'h0000007F};

  initial begin
    rst = 1'b0; req = '0; we = 1'b0; f3 = '0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1 req = 3'b111;
    @(posedge clk);
    #1 req = 3'b000;
    rst = 1'b1;

    op(3'b111, 1, 0, 1, 3'd2, 32'h10, 32'hDEADBEEF);
    chk("sw_err", 0, 32'(last_err[0]), 32'h0);
    op(3'b111, 1, 0, 0, 3'd2, 32'h10, 32'h0);
    for (int k = 0; k < 3; k++) chk("lw_10", k, last_rd[k], 32'hDEADBEEF);

    op(3'b111, 0, 0, 1, 3'd2, 32'h20, 32'h80F17F82);
    for (int i = 0; i < 5; i++) begin
      op(3'b111, 0, 0, 0, ext_f3[i], ext_a[i], 32'h0);
      chk("ext", 0, last_rd[0], ext_x[i]);
    end

    op(3'b111, 0, 0, 1, 3'd2, 32'h30, 32'h11223344);
    op(3'b111, 0, 0, 1, 3'd0, 32'h31, 32'hFFFFFFAA);
    op(3'b111, 1, 0, 1, 3'd1, 32'h32, 32'h1234BEEF);
    op(3'b111, 0, 0, 0, 3'd2, 32'h30, 32'h0);
    for (int k = 0; k < 3; k++) chk("partial", k, last_rd[k], 32'hBEEFAA44);

    op(3'b111, 0, 0, 1, 3'd2, 32'h40, 32'h0BADF00D);
    op(3'b111, 0, 0, 0, 3'd2, 32'h41, 32'h0);
    chk("misal_lw_err", 0, 32'(last_err[0]), 32'h1);
    chk("misal_lw_rd", 0, last_rd[0], 32'h0);
    op(3'b111, 0, 0, 1, 3'd1, 32'h43, 32'h0000FFFF);
    chk("misal_sh_err", 2, 32'(last_err[2]), 32'h1);
    op(3'b111, 0, 0, 0, 3'd3, 32'h40, 32'h0);
    chk("ill_ld_err", 1, 32'(last_err[1]), 32'h1);
    op(3'b111, 0, 0, 1, 3'd4, 32'h40, 32'h0);
    chk("ill_st_err", 0, 32'(last_err[0]), 32'h1);
    op(3'b111, 0, 0, 0, 3'd2, 32'h40, 32'h0);
    for (int k = 0; k < 3; k++) chk("err_keep", k, last_rd[k], 32'h0BADF00D);

    op(3'b111, 0, 0, 1, 3'd2, 32'h50, 32'h0);
    op(3'b111, 0, 1, 1, 3'd2, 32'h50, 32'h5555AAAA);
    op(3'b111, 0, 0, 0, 3'd2, 32'h50, 32'h0);
    for (int k = 0; k < 3; k++) chk("rst_drop", k, last_rd[k], 32'h0);

    op(3'b101, 1, 0, 0, 3'd5, 32'h12, 32'h0);
    chk("lhu_12", 2, last_rd[2], 32'h0000DEAD);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
